// File: rtl/ifetch_unit.sv
// Instruction fetch unit: one outstanding imem request, presents a word to IF/ID until PCWrite.
// Optional IFETCH_MISALIGN_EN macro: misaligned redirect targets park the unit and raise fetch_misalign.
module ifetch_unit (
  input  logic        cpu_clk,
  input  logic        reset,
  input  logic        PCWrite,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_opcplus4,
  output logic [31:0] IF_instruction,
  output logic        IF_valid,
  output logic        fetch_misalign
);

  typedef enum logic [1:0] {S_FETCH, S_HOLD, S_DISCARD} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        misalign_q, misalign_d;
  logic [31:0] redirect_tgt;
  logic        tgt_bad;

`ifdef IFETCH_MISALIGN_EN
  assign redirect_tgt = redirect_pc;
  assign tgt_bad      = |redirect_pc[1:0];
`else
  logic unused_tgt_lo;
  assign unused_tgt_lo = ^redirect_pc[1:0];
  assign redirect_tgt  = {redirect_pc[31:2], 2'b00};
  assign tgt_bad       = 1'b0;
`endif

  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      state_q    <= S_FETCH;
      pc_q       <= 32'd0;
      req_addr_q <= 32'd0;
      if_pc_q    <= 32'd0;
      instr_q    <= 32'd0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      if_pc_q    <= if_pc_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
    end
  end

  // Redirect outranks ack and PCWrite in every state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (redirect)      state_d = tgt_bad ? S_HOLD : (imem_ack ? S_FETCH : S_DISCARD);
        else if (imem_ack) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (redirect)                     state_d = tgt_bad ? S_HOLD : S_FETCH;
        else if (PCWrite && !misalign_q)  state_d = S_FETCH;
      end
      S_DISCARD: begin
        if (redirect && tgt_bad) state_d = S_HOLD;
        else if (imem_ack)       state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    if_pc_d    = if_pc_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    misalign_d = misalign_q;
    if (redirect) begin
      pc_d    = redirect_tgt;
      valid_d = 1'b0;
      if (tgt_bad) begin
        misalign_d = 1'b1;
      end else begin
        misalign_d = 1'b0;
        // Outstanding request keeps its address until the memory answers it
        if (state_q == S_HOLD || imem_ack) req_addr_d = redirect_tgt;
      end
    end else begin
      case (state_q)
        S_FETCH: begin
          if (imem_ack) begin
            instr_d = imem_rdata;
            if_pc_d = req_addr_q;
            valid_d = 1'b1;
          end
        end
        S_HOLD: begin
          if (PCWrite && !misalign_q) begin
            pc_d       = if_pc_q + 32'd4;
            req_addr_d = if_pc_q + 32'd4;
            valid_d    = 1'b0;
          end
        end
        S_DISCARD: begin
          if (imem_ack) req_addr_d = pc_q;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    imem_req       = !reset && (state_q != S_HOLD);
    imem_addr      = req_addr_q;
    IF_PC          = if_pc_q;
    IF_opcplus4    = if_pc_q + 32'd4;
    IF_instruction = valid_q ? instr_q : 32'd0;
    IF_valid       = valid_q;
`ifdef IFETCH_MISALIGN_EN
    fetch_misalign = misalign_q;
`else
    fetch_misalign = 1'b0;
`endif
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios, then random memory latency / PCWrite / redirect
// checked against a program-flow model (expected next PC, memory contents as a function of address).
module tb_ifetch_unit;

  logic        cpu_clk = 1'b0;
  logic        reset = 1'b1;
  logic        PCWrite = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] IF_PC, IF_opcplus4, IF_instruction;
  logic        IF_valid, fetch_misalign;

  int n_tests = 0;
  int n_fail  = 0;

  ifetch_unit dut (
    .cpu_clk(cpu_clk), .reset(reset), .PCWrite(PCWrite), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .IF_PC(IF_PC),
    .IF_opcplus4(IF_opcplus4), .IF_instruction(IF_instruction),
    .IF_valid(IF_valid), .fetch_misalign(fetch_misalign)
  );

  always #5 cpu_clk = ~cpu_clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it, and return 1 time unit after the edge
  task automatic cycle(input logic pcw, input logic rd, input logic [31:0] rpc, input logic ack);
    PCWrite     = pcw;
    redirect    = rd;
    redirect_pc = rpc;
    imem_ack    = ack;
    imem_rdata  = ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;
    @(posedge cpu_clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_next, prev_pc, prev_addr, rpc;
    logic        prev_v, prev_pcw, prev_rd, prev_pending, pcw, rd, ack;
    int          cnt, target, words;

    // Reset, with a stray ack that must be ignored
    reset = 1'b1;
    cycle(0, 0, 0, 1);
    cycle(1, 0, 0, 1);
    chk("rst_req", imem_req, 0);
    chk("rst_valid", IF_valid, 0);
    chk("rst_pc", IF_PC, 0);
    chk("rst_instr", IF_instruction, 0);
    chk("rst_opcp4", IF_opcplus4, 32'd4);
    chk("rst_misalign", fetch_misalign, 0);
    reset = 1'b0;
    #1;
    chk("rel_req", imem_req, 1);
    chk("rel_addr", imem_addr, 0);

    // Single-cycle memory, PCWrite held high: one word every 2 cycles
    for (int k = 0; k < 5; k++) begin
      chk("seq_valid", IF_valid, 32'(k % 2));
      if (k % 2 == 1) begin
        chk("seq_pc", IF_PC, 32'((k / 2) * 4));
        chk("seq_instr", IF_instruction, mem_word(32'((k / 2) * 4)));
        chk("seq_opcp4", IF_opcplus4, 32'((k / 2) * 4 + 4));
      end else begin
        chk("seq_req", imem_req, 1);
        chk("seq_addr", imem_addr, 32'((k / 2) * 4));
      end
      cycle(1, 0, 0, imem_req);
    end
    chk("hold8_valid", IF_valid, 1);
    chk("hold8_pc", IF_PC, 32'h8);

    // Stall in HOLD
    for (int k = 0; k < 5; k++) begin
      cycle(0, 0, 0, 0);
      chk("stall_valid", IF_valid, 1);
      chk("stall_pc", IF_PC, 32'h8);
      chk("stall_instr", IF_instruction, mem_word(32'h8));
      chk("stall_req", imem_req, 0);
    end
    cycle(1, 0, 0, 0);
    chk("after_stall_req", imem_req, 1);
    chk("after_stall_addr", imem_addr, 32'hC);
    chk("after_stall_valid", IF_valid, 0);

    // Redirect during a slow fetch
    cycle(0, 0, 0, 1);
    chk("hC_pc", IF_PC, 32'hC);
    cycle(1, 0, 0, 0);
    chk("f10_addr", imem_addr, 32'h10);
    cycle(0, 0, 0, 0);
    chk("f10_addr_w", imem_addr, 32'h10);
    cycle(0, 1, 32'h100, 0);
    chk("disc_req", imem_req, 1);
    chk("disc_addr", imem_addr, 32'h10);
    chk("disc_valid", IF_valid, 0);
    cycle(0, 0, 0, 0);
    chk("disc_addr_w", imem_addr, 32'h10);
    chk("disc_valid_w", IF_valid, 0);
    cycle(0, 0, 0, 1);
    chk("disc_next_addr", imem_addr, 32'h100);
    chk("disc_drop_valid", IF_valid, 0);
    cycle(0, 0, 0, 1);
    chk("h100_valid", IF_valid, 1);
    chk("h100_pc", IF_PC, 32'h100);
    chk("h100_instr", IF_instruction, mem_word(32'h100));

    // Redirect coincident with ack
    cycle(1, 0, 0, 0);
    chk("f104_addr", imem_addr, 32'h104);
    cycle(0, 1, 32'h200, 1);
    chk("rda_req", imem_req, 1);
    chk("rda_addr", imem_addr, 32'h200);
    chk("rda_valid", IF_valid, 0);
    cycle(0, 0, 0, 1);
    chk("h200_pc", IF_PC, 32'h200);

    // PC wrap at top of address space
    cycle(0, 1, 32'hFFFF_FFFC, 0);
    chk("wrap_faddr", imem_addr, 32'hFFFF_FFFC);
    cycle(0, 0, 0, 1);
    chk("wrap_pc", IF_PC, 32'hFFFF_FFFC);
    chk("wrap_opcp4", IF_opcplus4, 32'h0);
    cycle(1, 0, 0, 0);
    chk("wrap_next_addr", imem_addr, 32'h0);
    cycle(0, 0, 0, 1);
    chk("wrap_h0_pc", IF_PC, 32'h0);

    // Misaligned redirect target
`ifdef IFETCH_MISALIGN_EN
    cycle(0, 1, 32'h102, 0);
    chk("mis_req", imem_req, 0);
    chk("mis_valid", IF_valid, 0);
    chk("mis_flag", fetch_misalign, 1);
    cycle(1, 0, 0, 0);
    chk("mis_sticky_req", imem_req, 0);
    chk("mis_sticky_flag", fetch_misalign, 1);
    cycle(0, 1, 32'h104, 0);
    chk("mis_clr_flag", fetch_misalign, 0);
    chk("mis_clr_req", imem_req, 1);
    chk("mis_clr_addr", imem_addr, 32'h104);
`else
    cycle(0, 1, 32'h102, 0);
    chk("mis_flag", fetch_misalign, 0);
    chk("mis_req", imem_req, 1);
    chk("mis_addr", imem_addr, 32'h100);
`endif

    // Randomized phase, starting from a fresh reset
    reset = 1'b1;
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    reset = 1'b0;
    #1;
    exp_next = 32'd0; prev_v = 1'b0; prev_pending = 1'b0;
    prev_pcw = 1'b0; prev_rd = 1'b0; prev_pc = 32'd0; prev_addr = 32'd0;
    cnt = 0; target = $urandom_range(0, 3); words = 0;
    for (int c = 0; c < 4000; c++) begin
      chk("r_opcp4", IF_opcplus4, IF_PC + 32'd4);
      chk("r_misalign", fetch_misalign, 0);
      if (IF_valid) chk("r_hold_noreq", imem_req, 0);
      else          chk("r_nop", IF_instruction, 0);
      if (prev_pending) begin
        chk("r_req_held", imem_req, 1);
        chk("r_addr_stable", imem_addr, prev_addr);
      end
      if (prev_v && !prev_pcw && !prev_rd) begin
        chk("r_stall_valid", IF_valid, 1);
        chk("r_stall_pc", IF_PC, prev_pc);
      end
      if (IF_valid && !prev_v) begin
        words++;
        chk("r_flow_pc", IF_PC, exp_next);
        chk("r_instr", IF_instruction, mem_word(IF_PC));
      end

      rd  = ($urandom_range(0, 7) == 0);
      rpc = $urandom;
`ifdef IFETCH_MISALIGN_EN
      rpc[1:0] = 2'b00;
`endif
      pcw = ($urandom_range(0, 1) == 1);
      ack = 1'b0;
      if (imem_req) begin
        if (cnt >= target) begin
          ack = 1'b1; cnt = 0; target = $urandom_range(0, 3);
        end else begin
          cnt++;
        end
      end

      if (rd)                 exp_next = {rpc[31:2], 2'b00};
      else if (IF_valid && pcw) exp_next = IF_PC + 32'd4;
      prev_v = IF_valid; prev_pc = IF_PC; prev_pcw = pcw; prev_rd = rd;
      prev_pending = imem_req && !ack; prev_addr = imem_addr;
      cycle(pcw, rd, rpc, ack);
    end
    chk("r_progress", 32'(words >= 100), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
